// File: rtl/vgapat_pkg.sv
// Shared types and colour helpers for the multi-mode VGA test-pattern source.
package vgapat_pkg;

  localparam int unsigned MAX_BPC = 16;

  typedef logic [MAX_BPC-1:0] chan_t;

  typedef struct packed {
    chan_t r;
    chan_t g;
    chan_t b;
  } rgb_t;

  typedef enum logic [2:0] {
    MODE_BARS  = 3'd0,
    MODE_CHECK = 3'd1,
    MODE_RAMP  = 3'd2,
    MODE_HATCH = 3'd3,
    MODE_SOLID = 3'd4,
    MODE_BOX   = 3'd5,
    MODE_RSV6  = 3'd6,
    MODE_RSV7  = 3'd7
  } mode_e;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_e;

  function automatic chan_t chan_full(input int unsigned bpc);
    return chan_t'((32'd1 << bpc) - 32'd1);
  endfunction

  // 75% level: the two top bits set, everything below clear.
  function automatic chan_t chan_mid(input int unsigned bpc);
    return chan_t'(32'd3 << (bpc - 32'd2));
  endfunction

  function automatic rgb_t rgb_white(input int unsigned bpc);
    rgb_t c;
    c.r = chan_full(bpc);
    c.g = chan_full(bpc);
    c.b = chan_full(bpc);
    return c;
  endfunction

  function automatic rgb_t rgb_black();
    return '0;
  endfunction

  // Mid-level primaries/secondaries selected by an {R,G,B} enable mask.
  function automatic rgb_t rgb_mid(input int unsigned bpc, input logic [2:0] mask);
    rgb_t c;
    c.r = mask[2] ? chan_mid(bpc) : '0;
    c.g = mask[1] ? chan_mid(bpc) : '0;
    c.b = mask[0] ? chan_mid(bpc) : '0;
    return c;
  endfunction

  function automatic rgb_t rgb_dark_blue(input int unsigned bpc);
    rgb_t c;
    c   = '0;
    c.b = chan_t'(32'd2 << (bpc - 32'd2));
    return c;
  endfunction

  // Bar order: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [2:0] bar_mask(input logic [2:0] bar);
    logic [2:0] m;
    case (bar)
      3'd0:    m = 3'b111;
      3'd1:    m = 3'b110;
      3'd2:    m = 3'b011;
      3'd3:    m = 3'b010;
      3'd4:    m = 3'b101;
      3'd5:    m = 3'b100;
      3'd6:    m = 3'b001;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/vgapat_box.sv
// Bouncing-box position/direction state, stepped once per frame, plus an inside test.
module vgapat_box
  import vgapat_pkg::*;
#(
  parameter int unsigned HW    = 12,
  parameter int unsigned VW    = 12,
  parameter int unsigned BOXSZ = 32
) (
  input  logic          i_pixclk,
  input  logic          i_reset,
  input  logic          i_newframe,
  input  logic [HW-1:0] i_width,
  input  logic [VW-1:0] i_height,
  input  logic [HW-1:0] i_hpos,
  input  logic [VW-1:0] i_ypos,
  output logic [HW-1:0] o_bx,
  output logic [VW-1:0] o_by,
  output logic          o_inside_c
);

  localparam int unsigned HX = HW + 1;
  localparam int unsigned VX = VW + 1;

  logic [HW-1:0] bx_q, bx_d;
  logic [VW-1:0] by_q, by_d;
  dir_e          dx_q, dx_d;
  dir_e          dy_q, dy_d;

  always_ff @(posedge i_pixclk) begin
    if (i_reset) begin
      bx_q <= '0;
      by_q <= '0;
      dx_q <= DIR_POS;
      dy_q <= DIR_POS;
    end else begin
      bx_q <= bx_d;
      by_q <= by_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

  // Extra bit on every sum keeps the edge compares overflow-free.
  always_comb begin
    bx_d = bx_q;
    by_d = by_q;
    dx_d = dx_q;
    dy_d = dy_q;
    if (i_newframe) begin
      if (HX'(i_width) <= HX'(BOXSZ)) begin
        bx_d = '0;
      end else if (dx_q == DIR_POS) begin
        if (HX'(bx_q) + HX'(BOXSZ) + HX'(1) >= HX'(i_width)) begin
          dx_d = DIR_NEG;
          if (bx_q != '0) bx_d = bx_q - HW'(1);
        end else begin
          bx_d = bx_q + HW'(1);
        end
      end else if (bx_q == '0) begin
        dx_d = DIR_POS;
        bx_d = HW'(1);
      end else begin
        bx_d = bx_q - HW'(1);
      end

      if (VX'(i_height) <= VX'(BOXSZ)) begin
        by_d = '0;
      end else if (dy_q == DIR_POS) begin
        if (VX'(by_q) + VX'(BOXSZ) + VX'(1) >= VX'(i_height)) begin
          dy_d = DIR_NEG;
          if (by_q != '0) by_d = by_q - VW'(1);
        end else begin
          by_d = by_q + VW'(1);
        end
      end else if (by_q == '0) begin
        dy_d = DIR_POS;
        by_d = VW'(1);
      end else begin
        by_d = by_q - VW'(1);
      end
    end
  end

  assign o_bx = bx_q;
  assign o_by = by_q;
  assign o_inside_c = (HX'(i_hpos) >= HX'(bx_q)) && (HX'(i_hpos) < HX'(bx_q) + HX'(BOXSZ)) &&
                      (VX'(i_ypos) >= VX'(by_q)) && (VX'(i_ypos) < VX'(by_q) + VX'(BOXSZ));

endmodule

// File: rtl/vgapatgen.sv
// Multi-mode VGA test-pattern source: pixel counters, frame-synchronous mode latch,
// pattern mux and the registered pixel output.
module vgapatgen
  import vgapat_pkg::*;
#(
  parameter int unsigned BITS_PER_COLOR = 8,
  parameter int unsigned HW             = 12,
  parameter int unsigned VW             = 12,
  parameter int unsigned CHKLG          = 5,
  parameter int unsigned GRIDLG         = 6,
  parameter int unsigned BOXSZ          = 32
) (
  input  logic                        i_pixclk,
  input  logic                        i_reset,
  input  logic [HW-1:0]               i_width,
  input  logic [VW-1:0]               i_height,
  input  logic [2:0]                  i_mode,
  input  logic [3*BITS_PER_COLOR-1:0] i_color,
  input  logic                        i_rd,
  input  logic                        i_newline,
  input  logic                        i_newframe,
  output logic [3*BITS_PER_COLOR-1:0] o_pixel
);

  localparam int unsigned BPC = BITS_PER_COLOR;
  localparam int unsigned BPP = 3 * BPC;

  logic [HW-1:0]  hpos_q, hpos_d;
  logic [VW-1:0]  ypos_q, ypos_d;
  logic           dline_q, dline_d;
  mode_e          mode_q, mode_d;
  logic [BPP-1:0] color_q, color_d;
  logic [2:0]     bar_q, bar_d;
  logic [HW-1:0]  hedge_q, hedge_d;
  logic [BPP-1:0] pixel_q, pixel_d;

  logic [HW-1:0]  bar_step;
  logic           checker_c, hatch_c, inside_c;
  logic [BPP-1:0] pattern_c;
  // Box origin is only consumed through the inside flag here.
  logic [HW-1:0]  unused_bx;
  logic [VW-1:0]  unused_by;

  function automatic logic [BPP-1:0] to_pixel(input rgb_t c);
    return {BPC'(c.r), BPC'(c.g), BPC'(c.b)};
  endfunction

  assign bar_step = i_width >> 3;

  vgapat_box #(
    .HW    (HW),
    .VW    (VW),
    .BOXSZ (BOXSZ)
  ) u_box (
    .i_pixclk   (i_pixclk),
    .i_reset    (i_reset),
    .i_newframe (i_newframe),
    .i_width    (i_width),
    .i_height   (i_height),
    .i_hpos     (hpos_q),
    .i_ypos     (ypos_q),
    .o_bx       (unused_bx),
    .o_by       (unused_by),
    .o_inside_c (inside_c)
  );

  always_ff @(posedge i_pixclk) begin
    if (i_reset) begin
      hpos_q  <= '0;
      ypos_q  <= '0;
      dline_q <= 1'b0;
      mode_q  <= MODE_BARS;
      color_q <= '0;
      bar_q   <= '0;
      hedge_q <= bar_step;
      pixel_q <= '0;
    end else begin
      hpos_q  <= hpos_d;
      ypos_q  <= ypos_d;
      dline_q <= dline_d;
      mode_q  <= mode_d;
      color_q <= color_d;
      bar_q   <= bar_d;
      hedge_q <= hedge_d;
      pixel_q <= pixel_d;
    end
  end

  // Frame beats line beats pixel strobe; a strobe under a sync pulse is dropped.
  always_comb begin
    hpos_d  = hpos_q;
    ypos_d  = ypos_q;
    dline_d = dline_q;
    mode_d  = mode_q;
    color_d = color_q;
    bar_d   = bar_q;
    hedge_d = hedge_q;
    pixel_d = pixel_q;
    if (i_newframe) begin
      hpos_d  = '0;
      ypos_d  = '0;
      dline_d = 1'b0;
      mode_d  = mode_e'(i_mode);
      color_d = i_color;
      bar_d   = '0;
      hedge_d = bar_step;
    end else if (i_newline) begin
      hpos_d  = '0;
      if (dline_q) ypos_d = ypos_q + VW'(1);
      dline_d = 1'b0;
      bar_d   = '0;
      hedge_d = bar_step;
    end else if (i_rd) begin
      pixel_d = pattern_c;
      hpos_d  = hpos_q + HW'(1);
      dline_d = 1'b1;
      if (hpos_d >= hedge_q && bar_q != 3'd7) begin
        bar_d   = bar_q + 3'd1;
        hedge_d = hedge_q + bar_step;
      end
    end
  end

  assign checker_c = hpos_q[CHKLG] ^ ypos_q[CHKLG];
  assign hatch_c   = (hpos_q[GRIDLG-1:0] == '0) || (ypos_q[GRIDLG-1:0] == '0) ||
                     (hpos_q == i_width - HW'(1)) || (ypos_q == i_height - VW'(1));

  always_comb begin
    pattern_c = to_pixel(rgb_black());
    case (mode_q)
      MODE_BARS:  pattern_c = to_pixel(rgb_mid(BPC, bar_mask(bar_q)));
      MODE_CHECK: if (checker_c) pattern_c = to_pixel(rgb_white(BPC));
      MODE_RAMP:  pattern_c = {3{hpos_q[BPC-1:0]}};
      MODE_HATCH: if (hatch_c) pattern_c = to_pixel(rgb_white(BPC));
      MODE_SOLID: pattern_c = color_q;
      MODE_BOX:   pattern_c = inside_c ? to_pixel(rgb_white(BPC)) : to_pixel(rgb_dark_blue(BPC));
      default:    pattern_c = to_pixel(rgb_black());
    endcase
  end

  assign o_pixel = pixel_q;

endmodule

// File: doc/vgapatgen.md
# vgapatgen

Parametrised, multi-mode successor to the fixed colour-bar test source. It sits between the VGA timing generator and the pixel output stage and produces one registered pixel per `i_rd` strobe. The pattern is selected from colour bars, checkerboard, gray ramp, crosshatch, solid colour or a bouncing box. Mode changes take effect only at frame boundaries, so a frame never tears.

## Interface
- `BITS_PER_COLOR`, 8: bits per colour channel (BPC ≥ 4); BPP = 3·BPC, packed {R,G,B}.
- `HW`, 12: horizontal counter width.
- `VW`, 12: vertical counter width.
- `CHKLG`, 5: log2 of checkerboard cell size, in pixels.
- `GRIDLG`, 6: log2 of crosshatch pitch.
- `BOXSZ`, 32: bouncing box edge length, in pixels.

Ports (clock and reset first):
- `i_pixclk`, in, 1: pixel clock. Single clock domain.
- `i_reset`, in, 1: synchronous, active-high reset.
- `i_width`, in, HW: active width. Quasi-static.
- `i_height`, in, VW: active height. Quasi-static.
- `i_mode`, in, 3: pattern select. Sampled on `i_newframe`.
- `i_color`, in, BPP: solid-mode colour. Sampled on `i_newframe`.
- `i_rd`, in, 1: pixel request strobe.
- `i_newline`, in, 1: start of line.
- `i_newframe`, in, 1: start of frame.
- `o_pixel`, out, BPP: registered pixel.

## Operation
**Counters**
- `hpos` increments on each `i_rd`.
- `ypos` increments on `i_newline` only if at least one `i_rd` occurred since the previous newline or newframe (tracked by a `dline` flag).
- `i_newline` clears `hpos` and the bar state.
- `i_newframe` clears `hpos`, `ypos` and `dline`, latches `i_mode` into `mode_r`, latches `i_color`, and steps the box.

**Modes** (on `mode_r`; midlevel = 2'b11 followed by zeros, i.e. 75%)
- 0, colour bars: 8 bars, each `i_width>>3` wide. `hedge` accumulates in HW bits, and `bar` saturates at 7. Bar order: white, yellow, cyan, green, magenta, red, blue, black.
- 1, checkerboard: white if `hpos[CHKLG]^ypos[CHKLG]`, else black.
- 2, gray ramp: all channels = `hpos[BPC-1:0]`. Wraps every 2^BPC pixels.
- 3, crosshatch: white if `hpos[GRIDLG-1:0]==0`, or `ypos[GRIDLG-1:0]==0`, or `hpos==i_width-1`, or `ypos==i_height-1`; else black.
- 4, solid: latched `i_color`.
- 5, bouncing box: white inside `[bx,bx+BOXSZ)×[by,by+BOXSZ)`, else dark blue {0,0,0x2 followed by zeros}.
- 6, 7: black.

**Box motion** (on each `i_newframe`)
- `bx` moves ±1 per direction flag `dx`; `by` likewise with `dy`.
- If `dx=+` and `bx+BOXSZ+1 ≥ i_width`, flip `dx` and move `bx` by −1 instead. If `dx=−` and `bx==0`, flip `dx` and move by +1. Same rules for `by` against `i_height`.
- If `i_width ≤ BOXSZ`, hold `bx` at 0. Same for `by` against `i_height`.
- Compare sums in HW+1 bits, so there is no overflow.

**Priority**
- `i_reset` > `i_newframe` > `i_newline` > `i_rd`.
- When `i_newframe` or `i_newline` is asserted, a coincident `i_rd` is ignored: no `o_pixel` update and no `hpos` increment.

## Timing
- Reset values: `o_pixel=0`, `hpos=0`, `ypos=0`, `mode_r=0`, solid colour = 0, `bx=by=0`, `dx=dy=+`, `dline=0`.
- Latency is 1 cycle. On an `i_rd` cycle, `o_pixel` takes the colour for the current (`hpos`,`ypos`), and `hpos` then increments. Between `i_rd` strobes, `o_pixel` holds.
- Back-to-back `i_rd` gives one pixel per clock, with no bubbles.
- Any pattern pipelining must be internal and hidden; the 1-cycle `i_rd`→`o_pixel` contract is fixed.
- A mode or colour change mid-frame is invisible until the next `i_newframe`. The first pixel after that newframe already uses the new mode.
- If reset is asserted mid-line, the next pixel after reset release is mode 0, bar 0 (white).

## Structure
- Package `vgapat_pkg`:
  - mode encodings `MODE_BARS` … `MODE_BOX`;
  - BPC-parametrised colour constant functions: white, black, mid-level primaries and secondaries, dark blue.
- Sub-module `vgapat_box`: box position and direction state machine. It is clocked by `i_pixclk`, steps on `i_newframe`, and outputs `bx`, `by` and an `inside` flag for a given (`hpos`,`ypos`).
- Top level holds the counters, the mode latch and the output mux.

## Test plan
- Reset, width 640, height 480, mode 0, 640 `i_rd` → `o_pixel` is mid-white for pixels 0–79, mid-yellow for 80–159, …, black for 560–639. No output changes without `i_rd`.
- Mode 1, CHKLG=5 → pixel (32,0) = white, (0,0) = black, (32,32) = black.
- Mode 2, BPC=8 → pixel 255 = 0xFFFFFF and pixel 256 = 0x000000 (wrap).
- Assert `i_mode=4`, `i_color=0x123456` mid-frame → current frame unchanged; after next `i_newframe`, every pixel = 0x123456.
- Mode 5, width 40, height 480, BOXSZ 32 → across frames, `bx` follows 0,1,…,6 then 7, where `dx` flips so the next frame gives 6, then 5,…. Pixel (bx,by) = white; pixel (bx+32,by) = dark blue.
- `i_rd` coincident with `i_newline`, and `i_newframe` with `i_newline` → `hpos` stays 0, `o_pixel` is unchanged, and `ypos` resets to 0. Two newlines with no `i_rd` in between → `ypos` increments at most once.
